// File: rtl/fp64_cmp_pkg.sv
// rtl/fp64_cmp_pkg.sv - shared field widths, flag struct and FSM states for the shared fp64 comparator (FP64_CMP_NAN_EN selects core behaviour)
package fp64_cmp_pkg;

  localparam int SIGN_W = 1;
  localparam int EXP_W  = 11;
  localparam int MANT_W = 52;
  localparam int FP_W   = SIGN_W + EXP_W + MANT_W;

  localparam logic [EXP_W-1:0] EXP_MAX = 11'h7FF;

  typedef struct packed {
    logic eq;
    logic lt;
    logic gt;
    logic unord;
  } cmp_flags_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_e;

  // Magnitude field (exponent and mantissa) of a binary64 word; ordering of
  // same-signed values follows this as an unsigned integer.
  function automatic logic [FP_W-2:0] fp_mag(input logic [FP_W-1:0] x);
    return x[FP_W-2:0];
  endfunction

endpackage

// File: rtl/fp64_cmp_core.sv
// rtl/fp64_cmp_core.sv - combinational binary64 compare; FP64_CMP_NAN_EN selects IEEE (defined) or legacy (undefined) special cases
module fp64_cmp_core
  import fp64_cmp_pkg::*;
(
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  output cmp_flags_t      flags
);

  logic             sign_a;
  logic             sign_b;
  logic [EXP_W-1:0] exp_a;
  logic [EXP_W-1:0] exp_b;
  logic [FP_W-2:0]  mag_a;
  logic [FP_W-2:0]  mag_b;
  logic             ord_eq;
  logic             ord_lt;

  assign sign_a = a[FP_W-1];
  assign sign_b = b[FP_W-1];
  assign exp_a  = a[MANT_W +: EXP_W];
  assign exp_b  = b[MANT_W +: EXP_W];
  assign mag_a  = fp_mag(a);
  assign mag_b  = fp_mag(b);

  // Sign-magnitude ordering: differing signs decide directly, otherwise the
  // magnitude decides and its sense is reversed when both are negative.
  always_comb begin
    ord_eq = 1'b0;
    ord_lt = 1'b0;
    if (sign_a != sign_b) begin
      ord_lt = sign_a;
    end else begin
      ord_eq = (mag_a == mag_b);
      ord_lt = sign_a ? (mag_a > mag_b) : (mag_a < mag_b);
    end
  end

`ifdef FP64_CMP_NAN_EN
  logic nan_a;
  logic nan_b;
  logic both_zero;

  assign nan_a     = (exp_a == EXP_MAX) && (mag_a[MANT_W-1:0] != '0);
  assign nan_b     = (exp_b == EXP_MAX) && (mag_b[MANT_W-1:0] != '0);
  assign both_zero = (mag_a == '0) && (mag_b == '0);

  // NaN is unordered, +0 equals -0, infinities and subnormals order by value.
  always_comb begin
    flags = '0;
    if (nan_a || nan_b) begin
      flags.unord = 1'b1;
    end else if (both_zero) begin
      flags.eq = 1'b1;
    end else begin
      flags.eq = ord_eq;
      flags.lt = ord_lt;
      flags.gt = !ord_eq && !ord_lt;
    end
  end
`else
  // Legacy behaviour: max exponent raises all flags, zero exponent clears them.
  always_comb begin
    flags = '0;
    if ((exp_a == EXP_MAX) || (exp_b == EXP_MAX)) begin
      flags.eq = 1'b1;
      flags.lt = 1'b1;
      flags.gt = 1'b1;
    end else if ((exp_a == '0) || (exp_b == '0)) begin
      flags = '0;
    end else begin
      flags.eq = ord_eq;
      flags.lt = ord_lt;
      flags.gt = !ord_eq && !ord_lt;
    end
  end
`endif

endmodule

// File: rtl/fp64_cmp_arbiter.sv
// rtl/fp64_cmp_arbiter.sv - round-robin sharing of one fp64 compare core across NUM_REQ requesters (core mode via FP64_CMP_NAN_EN)
module fp64_cmp_arbiter
  import fp64_cmp_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*64-1:0] req_a,
  input  logic [NUM_REQ*64-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic                  rsp_eq,
  output logic                  rsp_lt,
  output logic                  rsp_gt,
  output logic                  rsp_unord,
  output logic                  busy
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_EVAL = EVAL;
  localparam logic [1:0] S_RESP = RESP;

  logic [1:0]      state;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] op_id;
  logic [63:0]     op_a;
  logic [63:0]     op_b;
  logic [ID_W-1:0] grant_id;
  logic [ID_W-1:0] cand;
  logic            grant_any;
  logic            take;
  cmp_flags_t      core_flags;
  cmp_flags_t      rsp_flags;

  // Round-robin search from ptr; scanning backwards lets the closest hit win.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    cand      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (req_valid[cand]) begin
        grant_any = 1'b1;
        grant_id  = cand;
      end
    end
  end

  assign take = (state == S_IDLE) && grant_any;

  // Only the winner sees ready, and only while idle and out of reset.
  always_comb begin
    req_ready = '0;
    if (!rst && take) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  fp64_cmp_core u_core (
    .a     (op_a),
    .b     (op_b),
    .flags (core_flags)
  );

  // Sequencer: capture the winner's operands, then one evaluate cycle, then hold the response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      ptr   <= '0;
      op_id <= '0;
      op_a  <= '0;
      op_b  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (take) begin
            op_a  <= req_a[int'(grant_id)*64 +: 64];
            op_b  <= req_b[int'(grant_id)*64 +: 64];
            op_id <= grant_id;
            ptr   <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
            state <= S_EVAL;
          end
        end
        S_EVAL: state <= S_RESP;
        S_RESP: begin
          if (rsp_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Response registers load at the end of EVAL and hold until the consumer accepts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_flags <= '0;
    end else if (state == S_EVAL) begin
      rsp_valid <= 1'b1;
      rsp_id    <= op_id;
      rsp_flags <= core_flags;
    end else if ((state == S_RESP) && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  assign rsp_eq    = rsp_flags.eq;
  assign rsp_lt    = rsp_flags.lt;
  assign rsp_gt    = rsp_flags.gt;
  assign rsp_unord = rsp_flags.unord;
  assign busy      = (state != S_IDLE);

endmodule

// File: doc/fp64_cmp_arbiter.md
# fp64_cmp_arbiter

Round-robin arbiter and sequencer that shares one double-precision (IEEE-754 binary64) comparator among NUM_REQ requesters. Each requester presents an operand pair over a valid/ready handshake. The block grants one requester at a time, registers its operands, evaluates the comparison, and returns the eq/lt/gt result with the requester ID over a second valid/ready handshake. It sits between the FP datapath clients and the compare core, so the core is never instantiated per client.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters, 2..16.
- ID_W, $clog2(NUM_REQ): width of the requester ID (derived, not overridden).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  NUM_REQ  per-requester operand pair valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  NUM_REQ*64  operand A, requester i at [64*i+63:64*i].
- req_b  in  NUM_REQ*64  operand B, same packing.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  result accepted by the consumer.
- rsp_id  out  ID_W  index of the requester this result belongs to.
- rsp_eq / rsp_lt / rsp_gt  out  1 each  comparison flags.
- rsp_unord  out  1  unordered result (NaN operand); see Configuration.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, EVAL, RESP.
- IDLE:
  - If any req_valid is high, pick winner g by round-robin from ptr: search ptr, ptr+1, …, wrapping mod NUM_REQ.
  - Drive req_ready[g]=1 combinationally; all other req_ready bits are 0.
  - On handshake, latch req_a[g], req_b[g] and g into operand/ID registers, set ptr = (g+1) mod NUM_REQ, go to EVAL.
  - With no req_valid high, stay in IDLE with req_ready = 0.
- EVAL: fp64_cmp_core evaluates the registered operands; flags and ID are registered into the response registers. Go to RESP.
- RESP:
  - rsp_valid=1; rsp_* outputs hold stable until rsp_ready.
  - On rsp_valid & rsp_ready, go to IDLE.
  - req_ready stays 0 throughout RESP and EVAL.
- Requester rule: once req_valid is asserted, it and its operands are held until req_ready. The block does not check this rule.
- Exactly one of eq/lt/gt is high for ordered operands (macro defined).
- Async reset in any state clears all registers immediately. Any in-flight request is discarded, not replayed; the requester re-presents it after reset.

## Timing
- Reset values: state=IDLE, ptr=0, rsp_valid=0, rsp_id=0, rsp_eq/lt/gt/unord=0, busy=0. While rst is high, req_ready=0.
- Latency: handshake accepted on edge T, then rsp_valid is high from edge T+2.
- Minimum issue interval: 3 cycles (IDLE, EVAL, RESP with rsp_ready already high). The next grant is in the IDLE cycle after the response is accepted.
- A simultaneous new req_valid and response acceptance in RESP does not produce a grant that cycle.
- ptr changes only on a request handshake. Requests that drop or appear while busy do not affect ptr.

## Configuration
Macro FP64_CMP_NAN_EN selects how fp64_cmp_core handles special operands.

Defined (IEEE-754 compare):
- Exponent 2047 with nonzero mantissa (NaN) on either operand: rsp_unord=1 and eq=lt=gt=0.
- ±Inf, zeros and subnormals compare by value; +0 == −0.

Undefined (legacy compare):
- Either exponent == 2047: eq=lt=gt=1.
- Otherwise either exponent == 0: eq=lt=gt=0.
- Otherwise sign, then exponent, then mantissa magnitude compare; order is inverted when both operands are negative.
- rsp_unord is tied 0.

## Structure
- Package fp64_cmp_pkg holds:
  - Constants: EXP_MAX=11'h7FF, field widths (sign 1, exponent 11, mantissa 52).
  - Packed struct cmp_flags_t {eq, lt, gt, unord}.
  - FSM state enum {IDLE, EVAL, RESP}.
- Sub-module fp64_cmp_core is purely combinational: two 64-bit operands in, cmp_flags_t out, with the macro selecting its special-case logic.
- The arbiter contains the FSM, the round-robin pointer, the operand/ID registers and the response registers.

## Test plan
- Req0 only, A=B=0x401599999999999A (5.4), handshake at T → rsp_valid at T+2, rsp_id=0, eq=1, lt=gt=0; busy high T+1..acceptance.
- All four req_valid high from reset, each with A=0x401CCCCCCCCCCCCD (7.2), B=0x4019333333333333 (6.3) → grants in order 0,1,2,3, each result gt=1, one response per 3 cycles with rsp_ready tied high.
- Req1 only, A=0xC019333333333333 (−6.3), B=0xC01CCCCCCCCCCCCD (−7.2) → gt=1. Then raise req0 and req1 together → req0 granted first, since ptr=2 wraps to 0.
- rsp_ready low for 5 cycles in RESP with req2 pending → rsp_* unchanged, req_ready stays 0. req2 is granted in the cycle after acceptance.
- A=0x7FF8000000000000 (NaN), B=0x3FF0000000000000 (1.0):
  - With the macro: unord=1, eq=lt=gt=0.
  - Without the macro: eq=lt=gt=1.
  - A=0x0, B=0x8000000000000000 with the macro: eq=1.
- rst asserted mid-EVAL → rsp_valid, busy and flags go to 0 without waiting for a clock edge, ptr=0. After release, the first request takes full T+2 latency.
